// File: rtl/gol_pkg.sv
// gol_pkg: shared state, reason and board-size definitions for the Game-of-Life sequencer and datapath
package gol_pkg;
  localparam int CELLS = 16;
  localparam int IDX_W = 4;
  typedef enum logic [3:0] {
    IDLE, LOAD, LWAIT, LCOMMIT, CAPTURE, EVAL, EWAIT, COMMIT, CHECK, DONE
  } golState_t;
  typedef enum logic [1:0] {
    R_NONE   = 2'b00,
    R_DIED   = 2'b01,
    R_STABLE = 2'b10,
    R_LIMIT  = 2'b11
  } golReason_t;
endpackage

// File: rtl/gol_cell_counter.sv
// gol_cell_counter: cell index counter with clear, enable and terminal-count flag
module gol_cell_counter
  import gol_pkg::*;
(
  input  logic             clka,
  input  logic             restart,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             tc
);
  always_ff @(posedge clka)
    if (!restart || clr) idx <= '0;
    else if (en) idx <= idx + 1'b1;
  assign tc = idx == IDX_W'(CELLS - 1);
endmodule

// File: rtl/gol_sequencer.sv
// gol_sequencer: control FSM that loads a seed and steps generations of the 4x4 torus datapath
module gol_sequencer
  import gol_pkg::*;
#(
  parameter int GEN_W   = 8,
  parameter int COUNT_W = 9
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               start,
  input  logic [CELLS-1:0]   seed,
  input  logic [GEN_W-1:0]   maxGen,
  input  logic               stop,
  input  logic               loseSig,
  input  logic [CELLS-1:0]   MuxData,
  output logic [COUNT_W-1:0] count,
  output logic               loadData,
  output logic               readData,
  output logic               writeData,
  output logic               writeout,
  output logic               DataIn,
  output logic               busy,
  output logic               done,
  output logic [1:0]         reason,
  output logic [GEN_W-1:0]   genCount
);
  golState_t        state, nextState;
  logic [CELLS-1:0] seedQ, prevQ;
  logic [GEN_W-1:0] maxGenQ;
  logic             stopPend, idleLike, died, stable, limit;
  logic [1:0]       nextReason;
  logic [IDX_W-1:0] idx;
  logic             tc, clr, en;
  gol_cell_counter u_counter (
    .clka   (clka),
    .restart(restart),
    .clr    (clr),
    .en     (en),
    .idx    (idx),
    .tc     (tc)
  );
  assign idleLike = state == IDLE || state == DONE;
  assign died     = loseSig;
  assign stable   = MuxData == prevQ;
  assign limit    = maxGenQ != '0 && genCount == maxGenQ;
  assign en       = state == LOAD || state == EVAL;
  assign clr      = (nextState == LOAD && state != LOAD) || (nextState == EVAL && state != EVAL);
  always_comb begin
    nextState  = state;
    nextReason = reason;
    case (state)
      IDLE, DONE: begin
        nextState  = start ? LOAD : state;
        nextReason = start ? R_NONE : reason;
      end
      LOAD:    nextState = tc ? LWAIT : LOAD;
      LWAIT:   nextState = LCOMMIT;
      LCOMMIT: nextState = CAPTURE;
      CAPTURE: nextState = EVAL;
      EVAL:    nextState = tc ? EWAIT : EVAL;
      EWAIT:   nextState = COMMIT;
      COMMIT:  nextState = CHECK;
      CHECK: begin
        nextState  = (died || stable || limit || stopPend) ? DONE : EVAL;
        nextReason = died ? R_DIED : stable ? R_STABLE : limit ? R_LIMIT : R_NONE;
      end
      default: nextState = IDLE;
    endcase
  end
  // strobes are computed from the next state so they rise in the cycle the state is entered
  always_ff @(posedge clka)
    if (!restart) begin
      state     <= IDLE;
      seedQ     <= '0;
      prevQ     <= '0;
      maxGenQ   <= '0;
      stopPend  <= 1'b0;
      genCount  <= '0;
      reason    <= '0;
      loadData  <= 1'b0;
      readData  <= 1'b0;
      writeData <= 1'b0;
      writeout  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nextState;
      reason    <= nextReason;
      loadData  <= nextState == LOAD;
      readData  <= nextState == EVAL;
      writeData <= nextState == LOAD || nextState == EVAL;
      writeout  <= nextState == LCOMMIT || nextState == COMMIT;
      busy      <= nextState != IDLE && nextState != DONE;
      done      <= nextState == DONE;
      if (idleLike && start) begin
        seedQ    <= seed;
        maxGenQ  <= maxGen;
        genCount <= '0;
        stopPend <= 1'b0;
      end else begin
        if (stop && !idleLike) stopPend <= 1'b1;
        if (state == COMMIT) genCount <= genCount + 1'b1;
        if (state == CAPTURE || (state == CHECK && nextState == EVAL)) prevQ <= MuxData;
      end
    end
  assign DataIn = loadData & seedQ[idx];
  assign count  = COUNT_W'({genCount[4:0], idx});
endmodule

// File: tb/tb_gol_sequencer.sv
// tb_gol_sequencer: scoreboard bench with a stub datapath for the Game-of-Life sequencer
module tb_gol_sequencer;
  logic        clka = 0, restart = 0, start = 0, stop = 0, loseSig = 0;
  logic [15:0] seed = '0, MuxData = '0;
  logic [7:0]  maxGen = '0;
  logic [8:0]  count;
  logic        loadData, readData, writeData, writeout, DataIn, busy, done;
  logic [1:0]  reason;
  logic [7:0]  genCount;
  int total = 0, bad = 0, stubMode = 0, commits = 0;
  typedef struct {logic [1:0] rsn; logic [7:0] gen; int busyCyc;} exp_t;
  exp_t sb[$];
  logic dq[$];
  gol_sequencer dut (
    .clka(clka), .restart(restart), .start(start), .seed(seed), .maxGen(maxGen),
    .stop(stop), .loseSig(loseSig), .MuxData(MuxData), .count(count),
    .loadData(loadData), .readData(readData), .writeData(writeData), .writeout(writeout),
    .DataIn(DataIn), .busy(busy), .done(done), .reason(reason), .genCount(genCount)
  );
  always #5 clka = ~clka;
  // stub datapath: new board after every commit, either always distinct or a fixed pattern
  always @(negedge clka)
    if (writeout) begin
      commits++;
      MuxData = stubMode == 1 ? 16'h0660 : 16'h1000 + 16'(commits * 7);
    end
  task automatic waitDone(input int budget, inout int n, output bit seen);
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clka);
      start = 0;
      stop = 0;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
    end
  endtask
  task automatic kick(input logic [15:0] s, input logic [7:0] mg, input logic [1:0] r, input logic [7:0] g);
    seed = s;
    maxGen = mg;
    start = 1;
    sb.push_back('{r, g, 19 * (1 + int'(g))});
  endtask
  task automatic test_reset;
    restart = 0;
    start = 1;
    seed = 16'hFFFF;
    maxGen = 8'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clka);
      total++;
      if ({loadData, readData, writeData, writeout, DataIn, busy, done, reason, genCount, count} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got=%h want=0", i, {loadData, readData, writeData, writeout, DataIn, busy, done, reason, genCount, count});
      end
    end
    restart = 1;
    start = 0;
    @(negedge clka);
    total++;
    if (busy !== 0 || loadData !== 0 || count !== 0) begin
      bad++;
      $display("FAIL reset_no_load busy=%b load=%b count=%h want 0 0 0", busy, loadData, count);
    end
  endtask
  task automatic test_load;
    int wo = 0, woCyc = -1, loads = 0, n = 0;
    bit seen;
    exp_t e;
    logic b;
    stubMode = 0;
    loseSig = 0;
    kick(16'hA5C3, 8'd1, 2'b11, 8'd1);
    for (int i = 0; i < 16; i++) dq.push_back(seed[i]);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clka);
      start = 0;
      if (busy) n++;
      if (writeout) begin
        wo++;
        woCyc = c;
      end
      if (loadData) begin
        b = dq.size() != 0 ? dq.pop_front() : 1'bx;
        total++;
        if (DataIn !== b || writeData !== 1 || readData !== 0 || count[3:0] !== 4'(loads)) begin
          bad++;
          $display("FAIL load_bit idx=%0d got din=%b wd=%b rd=%b cnt=%0d want din=%b wd=1 rd=0 cnt=%0d", loads, DataIn, writeData, readData, count[3:0], b, loads);
        end
        loads++;
      end
    end
    total++;
    if (loads != 16 || dq.size() != 0 || wo != 1 || woCyc != 18) begin
      bad++;
      $display("FAIL load_frame got loads=%0d left=%0d wo=%0d at %0d want 16 0 1 at 18", loads, dq.size(), wo, woCyc);
    end
    waitDone(200, n, seen);
    e = sb.pop_front();
    total++;
    if (!seen || reason !== e.rsn || genCount !== e.gen || n != e.busyCyc) begin
      bad++;
      $display("FAIL load_end seen=%0d got r=%b g=%0d busy=%0d want r=%b g=%0d busy=%0d", seen, reason, genCount, n, e.rsn, e.gen, e.busyCyc);
    end
  endtask
  task automatic test_limit;
    int n = 0;
    bit seen;
    exp_t e;
    stubMode = 0;
    kick(16'h1234, 8'd3, 2'b11, 8'd3);
    waitDone(300, n, seen);
    e = sb.pop_front();
    total++;
    if (!seen || reason !== e.rsn || genCount !== e.gen || n != e.busyCyc || count[8:4] !== 5'd3) begin
      bad++;
      $display("FAIL limit seen=%0d got r=%b g=%0d busy=%0d c84=%0d want r=%b g=%0d busy=%0d c84=3", seen, reason, genCount, n, count[8:4], e.rsn, e.gen, e.busyCyc);
    end
  endtask
  task automatic test_stable;
    int n = 0;
    bit seen;
    exp_t e;
    stubMode = 1;
    kick(16'h0660, 8'd0, 2'b10, 8'd1);
    waitDone(300, n, seen);
    e = sb.pop_front();
    total++;
    if (!seen || reason !== e.rsn || genCount !== e.gen || n != e.busyCyc) begin
      bad++;
      $display("FAIL stable seen=%0d got r=%b g=%0d busy=%0d want r=%b g=%0d busy=%0d", seen, reason, genCount, n, e.rsn, e.gen, e.busyCyc);
    end
  endtask
  task automatic test_died;
    int n = 0;
    bit seen;
    exp_t e;
    stubMode = 1;
    loseSig = 1;
    kick(16'h0660, 8'd1, 2'b01, 8'd1);
    waitDone(300, n, seen);
    e = sb.pop_front();
    total++;
    if (!seen || reason !== e.rsn || genCount !== e.gen || n != e.busyCyc) begin
      bad++;
      $display("FAIL died seen=%0d got r=%b g=%0d busy=%0d want r=%b g=%0d busy=%0d", seen, reason, genCount, n, e.rsn, e.gen, e.busyCyc);
    end
    loseSig = 0;
  endtask
  task automatic test_back_to_back;
    int n = 0;
    bit seen;
    exp_t e;
    stubMode = 0;
    kick(16'h8001, 8'd2, 2'b11, 8'd2);
    @(negedge clka);
    start = 0;
    if (busy) n++;
    total++;
    if (done !== 0 || reason !== 0 || genCount !== 0 || count !== 0 || loadData !== 1 || DataIn !== 1) begin
      bad++;
      $display("FAIL b2b_restart got done=%b r=%b g=%0d cnt=%h ld=%b din=%b want 0 0 0 0 1 1", done, reason, genCount, count, loadData, DataIn);
    end
    waitDone(300, n, seen);
    e = sb.pop_front();
    total++;
    if (!seen || reason !== e.rsn || genCount !== e.gen || n != e.busyCyc) begin
      bad++;
      $display("FAIL b2b_end seen=%0d got r=%b g=%0d busy=%0d want r=%b g=%0d busy=%0d", seen, reason, genCount, n, e.rsn, e.gen, e.busyCyc);
    end
  endtask
  task automatic test_stop;
    int n = 0;
    bit seen;
    exp_t e;
    stubMode = 0;
    kick(16'h00F0, 8'd0, 2'b00, 8'd1);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clka);
      start = 0;
      if (busy) n++;
    end
    stop = 1;
    start = 1;
    waitDone(300, n, seen);
    e = sb.pop_front();
    total++;
    if (!seen || reason !== e.rsn || genCount !== e.gen || n != e.busyCyc) begin
      bad++;
      $display("FAIL stop seen=%0d got r=%b g=%0d busy=%0d want r=%b g=%0d busy=%0d", seen, reason, genCount, n, e.rsn, e.gen, e.busyCyc);
    end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    bit seen, hit = 0;
    exp_t e;
    stubMode = 0;
    seed = 16'hFFFF;
    maxGen = 8'd0;
    start = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clka);
      start = 0;
      if (readData && count[3:0] == 4'd7) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_reach got idx7=0 want 1");
    end
    restart = 0;
    @(negedge clka);
    total++;
    if ({loadData, readData, writeData, writeout, DataIn, busy, done, reason, genCount, count} !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%h want=0", {loadData, readData, writeData, writeout, DataIn, busy, done, reason, genCount, count});
    end
    restart = 1;
    @(negedge clka);
    kick(16'h0001, 8'd2, 2'b11, 8'd2);
    @(negedge clka);
    start = 0;
    if (busy) n++;
    total++;
    if (loadData !== 1 || count !== 0 || genCount !== 0 || DataIn !== 1) begin
      bad++;
      $display("FAIL mid_newload got ld=%b cnt=%h g=%0d din=%b want 1 0 0 1", loadData, count, genCount, DataIn);
    end
    waitDone(300, n, seen);
    e = sb.pop_front();
    total++;
    if (!seen || reason !== e.rsn || genCount !== e.gen || n != e.busyCyc) begin
      bad++;
      $display("FAIL mid_end seen=%0d got r=%b g=%0d busy=%0d want r=%b g=%0d busy=%0d", seen, reason, genCount, n, e.rsn, e.gen, e.busyCyc);
    end
  endtask
  initial begin
    test_reset;
    test_load;
    test_limit;
    test_stable;
    test_died;
    test_back_to_back;
    test_stop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gol_sequencer.md
Name: gol_sequencer

Overview:
Single-clock control FSM that sits directly upstream of the Game-of-Life 4x4 torus datapath and drives all of its control inputs.
- Serialises a 16-bit seed board into the datapath's DataIn.
- Steps generations: evaluate 16 cells, commit, check.
- Terminates on extinction (loseSig), a stable board, or a generation limit, and reports which.

Parameters:
CELLS, 16, board cells per generation (4x4 torus)
IDX_W, 4, cell index width, log2(CELLS)
GEN_W, 8, generation counter width
COUNT_W, 9, width of count bus to datapath

Ports:
clka  in  1  sole clock, all state updates on rising edge
restart  in  1  synchronous, active-low reset
start  in  1  one-cycle strobe; accepted in IDLE or DONE, samples seed and maxGen
seed  in  16  initial board, bit i = cell i
maxGen  in  GEN_W  generation limit; 0 = no limit
stop  in  1  finish current generation, then go to DONE
loseSig  in  1  extinction flag from datapath
MuxData  in  16  committed board from datapath
count  out  COUNT_W  [3:0] cell index, [8:4] genCount[4:0]
loadData  out  1  datapath load-seed select
readData  out  1  datapath evaluate select
writeData  out  1  datapath cell write enable
writeout  out  1  datapath board commit strobe
DataIn  out  1  seed bit for current cell
busy  out  1  high in every state except IDLE/DONE
done  out  1  level, high in DONE
reason  out  2  00 none, 01 DIED, 10 STABLE, 11 LIMIT
genCount  out  GEN_W  completed generations

Behaviour:
- Reset (restart=0 at edge): state IDLE; all outputs 0; seed/limit/prev-board registers cleared. Reset wins over every other input, in any state, mid-operation included.
- States, cycle by cycle:
  - IDLE: on start, latch seed and maxGen, clear genCount/reason/stop_pend, idx=0, go to LOAD.
  - LOAD (16 cycles): loadData=1, writeData=1, DataIn=seed_q[idx], count[3:0]=idx; idx increments. idx=15 goes to LWAIT.
  - LWAIT (1): all strobes 0; datapath settles next board.
  - LCOMMIT (1): writeout=1, then CAPTURE.
  - CAPTURE (1): prev_q<=MuxData, idx=0, then EVAL.
  - EVAL (16 cycles): readData=1, writeData=1, DataIn=0, count[3:0]=idx. idx=15 goes to EWAIT.
  - EWAIT (1): all strobes 0.
  - COMMIT (1): writeout=1; genCount+=1 (wraps at 2^GEN_W).
  - CHECK (1): evaluate termination in priority order: loseSig=1 -> DIED; MuxData==prev_q -> STABLE; maxGen!=0 and genCount==maxGen -> LIMIT; stop_pend -> reason 00. If any fires, go to DONE. Otherwise prev_q<=MuxData, idx=0, go to EVAL.
  - DONE: done=1, reason held, strobes 0; start restarts exactly as from IDLE.
- Every phase is 19 cycles. Start to done = 19*(1+N) cycles for N generations.
- stop: sets stop_pend in any busy state; ignored in IDLE/DONE. start while busy is ignored.
- Strobes are registered outputs, asserted in the cycle the state is entered. At most one of loadData/readData is high; writeout never overlaps writeData.
- count[8:4] shows genCount[4:0]; upper genCount bits are visible only on genCount.
- Simultaneous start and restart=0: reset wins.

Decomposition:
- Package gol_pkg: state enum (IDLE, LOAD, LWAIT, LCOMMIT, CAPTURE, EVAL, EWAIT, COMMIT, CHECK, DONE), reason codes, CELLS/IDX_W constants. The datapath shares the package.
- One sub-module, gol_cell_counter: IDX_W index counter with clear, enable and terminal-count flag; used by both LOAD and EVAL.

Test Plan:
1. Reset: hold restart=0 for 2 cycles with start=1 -> all outputs 0, busy=0, count=0; no LOAD entry.
2. Load serialisation: start with seed=0xA5C3.
   - DataIn over 16 LOAD cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with loadData=writeData=1 and count 0..15.
   - writeout pulses exactly once, on cycle 18.
3. Limit: maxGen=3; stub datapath keeps loseSig=0 and returns a different MuxData each commit -> done at cycle 76, reason=11, genCount=3, count[8:4]=3.
4. Stable: stub returns 0x0660 after the load and after gen 1 -> CHECK of gen 1 gives reason=10, genCount=1.
5. Died priority: loseSig=1 and MuxData==prev_q in the same CHECK, maxGen=1 -> reason=01; stable and limit are ignored.
6. Reset mid-EVAL at idx=7, then start one cycle after release -> outputs 0 the cycle after the reset edge; new LOAD begins with count=0 and genCount=0.
